seg_display_arbiter: RTL and testbench

- Shares the single 8-digit seven-segment display among up to N_REQ vending-machine sub-controllers (idle banner, product browse, payment, fault) and sequences its digit scan.
- Arbitration is fixed-priority. Each grant has a minimum hold time, and ownership changes only at frame boundaries, so a message never tears mid-scan.
- Outputs a one-hot digit enable and a 4-bit character code per digit. These feed the segment decoder/pin-inversion stage.

---
 rtl/seg_pkg.sv | 68 ++++++
 rtl/seg_display_arbiter_if.sv | 23 ++
 rtl/seg_scan_timer.sv | 39 +++
 rtl/seg_display_arbiter.sv | 150 +++++++++++++++
 tb/tb_seg_display_arbiter.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display path: char codes, arbiter
// state encodings and the segment patterns the downstream decoder drives.
package seg_pkg;

  // Character codes carried on the 4-bit char bus
  localparam logic [3:0] CHAR_0     = 4'h0;
  localparam logic [3:0] CHAR_1     = 4'h1;
  localparam logic [3:0] CHAR_2     = 4'h2;
  localparam logic [3:0] CHAR_3     = 4'h3;
  localparam logic [3:0] CHAR_4     = 4'h4;
  localparam logic [3:0] CHAR_5     = 4'h5;
  localparam logic [3:0] CHAR_6     = 4'h6;
  localparam logic [3:0] CHAR_7     = 4'h7;
  localparam logic [3:0] CHAR_8     = 4'h8;
  localparam logic [3:0] CHAR_9     = 4'h9;
  localparam logic [3:0] CHAR_P     = 4'hA;
  localparam logic [3:0] CHAR_C     = 4'hB;
  localparam logic [3:0] CHAR_S     = 4'hC;
  localparam logic [3:0] CHAR_E     = 4'hE;
  localparam logic [3:0] CHAR_BLANK = 4'hF;

  // Arbiter states
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t HOLD = 2'd1;
  localparam state_t OPEN = 2'd2;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_P     = 7'h73;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_S     = 7'h6D;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Char code to segment pattern; unassigned codes render blank
  function automatic logic [6:0] char_to_seg(logic [3:0] code);
    logic [6:0] seg;
    case (code)
      CHAR_0:  seg = SEG_0;
      CHAR_1:  seg = SEG_1;
      CHAR_2:  seg = SEG_2;
      CHAR_3:  seg = SEG_3;
      CHAR_4:  seg = SEG_4;
      CHAR_5:  seg = SEG_5;
      CHAR_6:  seg = SEG_6;
      CHAR_7:  seg = SEG_7;
      CHAR_8:  seg = SEG_8;
      CHAR_9:  seg = SEG_9;
      CHAR_P:  seg = SEG_P;
      CHAR_C:  seg = SEG_C;
      CHAR_S:  seg = SEG_S;
      CHAR_E:  seg = SEG_E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Requester/display bundle of the display arbiter. The requester side
// (master) drives req/msg; the arbiter (slave) drives grant and scan outputs.
interface seg_display_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*32-1:0] msg;
  logic [N_REQ-1:0]    grant;
  logic                busy;
  logic [7:0]          dig_en;
  logic [3:0]          char;
  logic                frame_end;

  modport master (
    output req, msg,
    input  grant, busy, dig_en, char, frame_end
  );

  modport slave (
    input  req, msg,
    output grant, busy, dig_en, char, frame_end
  );
endinterface

// File: rtl/seg_scan_timer.sv
// Digit scan timebase: prescaler per digit slot, 0..7 digit index and the
// frame_end pulse on the last cycle of digit 7.
module seg_scan_timer #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] index_next,
  output logic       frame_end
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    index_q;
  logic          wrap;

  // Next prescaler/index; index_next is exported so registered outputs
  // downstream line up with the digit that becomes active on the edge.
  always_comb begin
    wrap       = (pre_q == PRE_LAST);
    pre_d      = wrap ? '0 : pre_q + PW'(1);
    index_next = wrap ? index_q + 3'd1 : index_q;
    frame_end  = wrap && (index_q == 3'd7);
  end

  // Scan counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q   <= '0;
      index_q <= 3'd0;
    end else begin
      pre_q   <= pre_d;
      index_q <= index_next;
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Fixed-priority owner arbitration for the shared 8-digit display. Ownership
// only changes on frame boundaries and is held for at least MIN_HOLD frames;
// a requester that drops while owning keeps showing its last message.
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned MIN_HOLD = 250
) (
  input logic                  clk,
  input logic                  rst,
  seg_display_arbiter_if.slave bus
);

  localparam int unsigned HW = $clog2(MIN_HOLD + 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  logic [2:0]       index_next;
  logic             frame_end;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [31:0]      latch_q, latch_d;
  logic [7:0]       dig_en_q, dig_en_d;
  logic [3:0]       char_q, char_d;

  logic [N_REQ-1:0] higher, others;
  logic             owner_req, apply_open;
  logic [31:0]      owner_word, disp_word;
  logic             owner_req_d;

  seg_scan_timer #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan_timer (
    .clk       (clk),
    .rst       (rst),
    .index_next(index_next),
    .frame_end (frame_end)
  );

  // Lowest set bit as one-hot (index 0 is highest priority)
  function automatic logic [N_REQ-1:0] pick_first(logic [N_REQ-1:0] v);
    logic [N_REQ-1:0] p;
    p = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        p    = '0;
        p[i] = 1'b1;
      end
    end
    return p;
  endfunction

  // Arbitration decisions, evaluated only on frame_end
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    hold_d     = hold_q;
    apply_open = 1'b0;
    // grant_q is one-hot here, so grant_q-1 masks all higher-priority lines
    higher     = bus.req & (grant_q - ONE);
    others     = bus.req & ~grant_q;
    owner_req  = |(bus.req & grant_q);

    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (|bus.req) begin
            grant_d = pick_first(bus.req);
            hold_d  = HW'(MIN_HOLD);
            state_d = HOLD;
          end
        end
        HOLD: begin
          // Last held frame: the hold ends now and OPEN rules apply at once
          if (hold_q == HW'(1)) apply_open = 1'b1;
          else                  hold_d     = hold_q - HW'(1);
        end
        OPEN:    apply_open = 1'b1;
        default: begin
          state_d = IDLE;
          grant_d = '0;
          hold_d  = '0;
        end
      endcase

      if (apply_open) begin
        if (|higher) begin
          grant_d = pick_first(higher);
          hold_d  = HW'(MIN_HOLD);
          state_d = HOLD;
        end else if (!owner_req) begin
          if (|others) begin
            grant_d = pick_first(others);
            hold_d  = HW'(MIN_HOLD);
            state_d = HOLD;
          end else begin
            grant_d = '0;
            hold_d  = '0;
            state_d = IDLE;
          end
        end else begin
          hold_d  = '0;
          state_d = OPEN;
        end
      end
    end
  end

  // Message latch and next char for the digit that is active after the edge
  always_comb begin
    owner_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_d[i]) owner_word = bus.msg[32*i +: 32];
    end
    owner_req_d = |(bus.req & grant_d);
    latch_d     = owner_req_d ? owner_word : latch_q;
    disp_word   = owner_req_d ? owner_word : latch_q;
    char_d      = (|grant_d) ? disp_word[{index_next, 2'b00} +: 4] : CHAR_BLANK;
    dig_en_d    = 8'b0000_0001 << index_next;
  end

  // Arbiter and display registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      hold_q   <= '0;
      latch_q  <= '0;
      dig_en_q <= 8'b0000_0001;
      char_q   <= CHAR_BLANK;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      hold_q   <= hold_d;
      latch_q  <= latch_d;
      dig_en_q <= dig_en_d;
      char_q   <= char_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.busy      = |grant_q;
  assign bus.dig_en    = dig_en_q;
  assign bus.char      = char_q;
  assign bus.frame_end = frame_end;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter with N_REQ=4, SCAN_DIV=2, MIN_HOLD=2.
// Per-frame expectations (owner, displayed word) and timed req/msg changes
// are queued up front; each frame pops one expectation and compares it.
module tb_seg_display_arbiter;

  localparam logic [31:0] W0    = 32'hEDCB_A987;
  localparam logic [31:0] W1    = 32'h2468_ACE0;
  localparam logic [31:0] W2    = 32'h1234_5678;
  localparam logic [31:0] W3    = 32'hBEAD_3210;
  localparam logic [31:0] WX    = 32'hAAAA_0009;
  localparam logic [31:0] BLANK = 32'hFFFF_FFFF;
  localparam logic [127:0] M_BASE = {W3, W2, W1, W0};
  localparam logic [127:0] M_X    = {W3, W2, WX, W0};

  typedef struct {
    int           frame;
    int           cycle;
    logic [3:0]   req;
    logic [127:0] msg;
  } act_t;

  typedef struct {
    logic [3:0]  grant;
    logic [31:0] word;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   fno;
  act_t act_q[$];
  exp_t exp_q[$];

  seg_display_arbiter_if #(.N_REQ(4)) bus ();

  seg_display_arbiter #(
    .N_REQ   (4),
    .SCAN_DIV(2),
    .MIN_HOLD(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_act(input int f, input int c, input logic [3:0] r, input logic [127:0] m);
    act_t a;
    a.frame = f;
    a.cycle = c;
    a.req   = r;
    a.msg   = m;
    act_q.push_back(a);
  endtask

  task automatic push_exp(input logic [3:0] g, input logic [31:0] w);
    exp_t e;
    e.grant = g;
    e.word  = w;
    exp_q.push_back(e);
  endtask

  // Entered at the negedge of cycle 0 of a frame; leaves at cycle 0 of the next
  task automatic run_frame();
    exp_t e;
    if (exp_q.size() == 0) begin
      check($sformatf("f%0d_no_expect", fno), 32'd0, 32'd1);
      e.grant = 4'b0000;
      e.word  = BLANK;
    end else begin
      e = exp_q.pop_front();
    end
    for (int j = 0; j < 16; j++) begin
      if (j % 2 == 1) begin
        check($sformatf("f%0d_dig_en%0d", fno, j / 2), 32'(bus.dig_en),
              32'(8'b0000_0001 << (j / 2)));
        check($sformatf("f%0d_char%0d", fno, j / 2), 32'(bus.char),
              32'(e.word[4*(j/2) +: 4]));
      end
      if (j == 1 || j == 15) begin
        check($sformatf("f%0d_grant_c%0d", fno, j), 32'(bus.grant), 32'(e.grant));
      end
      if (j == 1) check($sformatf("f%0d_busy", fno), 32'(bus.busy), 32'(e.grant != 4'b0000));
      if (j == 13) check($sformatf("f%0d_fe_early", fno), 32'(bus.frame_end), 32'd0);
      if (j == 15) check($sformatf("f%0d_fe", fno), 32'(bus.frame_end), 32'd1);
      while (act_q.size() > 0 && act_q[0].frame == fno && act_q[0].cycle == j) begin
        bus.req = act_q[0].req;
        bus.msg = act_q[0].msg;
        void'(act_q.pop_front());
      end
      @(negedge clk);
    end
    fno++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    n_checks = 0;
    n_errors = 0;
    fno      = 0;
    rst      = 1'b0;
    bus.req  = 4'b0000;
    bus.msg  = M_BASE;

    // Reset mid-scan
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (7) @(negedge clk);
    check("pre_reset_dig_en", 32'(bus.dig_en), 32'h08);
    rst = 1'b0;
    #1;
    check("rst_dig_en", 32'(bus.dig_en), 32'h01);
    check("rst_char", 32'(bus.char), 32'hF);
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_frame_end", 32'(bus.frame_end), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    cnt = 1;
    while (bus.frame_end !== 1'b1 && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("first_frame_end_cycle", 32'(cnt), 32'd16);
    @(negedge clk);

    // Single owner, then drop during hold
    push_act(0, 0, 4'b0100, M_BASE);
    push_exp(4'b0000, BLANK);
    push_exp(4'b0100, W2);
    push_act(2, 5, 4'b0000, M_BASE);
    push_exp(4'b0100, W2);
    // Preemption honours the hold
    push_act(3, 0, 4'b1000, M_BASE);
    push_exp(4'b0000, BLANK);
    push_act(4, 2, 4'b1001, M_BASE);
    push_exp(4'b1000, W3);
    push_exp(4'b1000, W3);
    push_act(6, 0, 4'b0001, M_BASE);
    push_exp(4'b0001, W0);
    push_exp(4'b0001, W0);
    // Owner drop and new requests on the same frame_end
    push_act(8, 15, 4'b1100, M_BASE);
    push_exp(4'b0001, W0);
    push_act(9, 0, 4'b1110, M_BASE);
    push_exp(4'b0100, W2);
    push_exp(4'b0100, W2);
    // Lower priority never preempts
    push_act(11, 0, 4'b1010, M_BASE);
    push_exp(4'b0010, W1);
    push_exp(4'b0010, W1);
    push_exp(4'b0010, W1);
    push_exp(4'b0010, W1);
    push_act(15, 4, 4'b1000, M_BASE);
    push_exp(4'b0010, W1);
    push_act(16, 0, 4'b0000, M_BASE);
    push_exp(4'b1000, W3);
    push_exp(4'b1000, W3);
    // Drop during hold after a live msg change
    push_act(18, 0, 4'b0010, M_BASE);
    push_exp(4'b0000, BLANK);
    push_act(19, 0, 4'b0010, M_X);
    push_act(19, 6, 4'b0000, M_X);
    push_exp(4'b0010, WX);
    push_exp(4'b0010, WX);
    push_exp(4'b0000, BLANK);

    while (exp_q.size() > 0) run_frame();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
